// File: rtl/pixel_scheduler_pkg.sv
// Shared types and constants for the pixel scheduler.
//   state_e    : scheduler FSM states
//   fb_pixel_t : packed 4:4:4 RGB frame-buffer word
//   BayerTable : 2x2 ordered-dither thresholds, indexed by {y[0], x[0]}
//   sat_add8   : 8-bit add that clamps at 255
package pixel_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StWrite
  } state_e;

  typedef logic [11:0] fb_pixel_t;

  localparam logic [3:0] BayerTable [4] = '{4'd0, 4'd8, 4'd12, 4'd4};

  function automatic logic [7:0] sat_add8(logic [7:0] a, logic [3:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {5'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/pixel_scheduler_pack.sv
// pixel_pack: combinational colour packer. Truncates three 8-bit channels to a
// 12-bit 4:4:4 word. With PIXEL_DITHER_EN defined, a 2x2 Bayer threshold chosen
// by the pixel's coordinate parity is added (saturating) before truncation.
// Ports:
//   red_i/green_i/blue_i : registered colour channels
//   x0_i/y0_i            : LSBs of the pixel coordinate
//   pixel_o              : packed {r[7:4], g[7:4], b[7:4]}
module pixel_pack
  import pixel_scheduler_pkg::*;
(
  input  logic [7:0]  red_i,
  input  logic [7:0]  green_i,
  input  logic [7:0]  blue_i,
  input  logic        x0_i,
  input  logic        y0_i,
  output logic [11:0] pixel_o
);

`ifdef PIXEL_DITHER_EN
  logic [3:0] thr;
  logic [7:0] red_d, green_d, blue_d;

  assign thr     = BayerTable[{y0_i, x0_i}];
  assign red_d   = sat_add8(red_i, thr);
  assign green_d = sat_add8(green_i, thr);
  assign blue_d  = sat_add8(blue_i, thr);
  assign pixel_o = {red_d[7:4], green_d[7:4], blue_d[7:4]};
`else
  logic unused_coord;
  assign unused_coord = x0_i ^ y0_i;
  assign pixel_o      = {red_i[7:4], green_i[7:4], blue_i[7:4]};
`endif

endmodule

// File: rtl/pixel_scheduler.sv
// pixel_scheduler: walks a WIDTH x HEIGHT frame in raster order (x fastest),
// launching one raymarcher job per pixel and writing its colour to a frame
// buffer. A pixel that does not finish within TIMEOUT_CYCLES is written as
// black and counted.
// Optional build macro: PIXEL_DITHER_EN (2x2 Bayer dither in pixel_pack).
// Ports:
//   clk_pixel_in, rst_in          : clock, synchronous active-high reset
//   start_in, busy_out            : frame start pulse, frame in progress
//   frame_done_out                : one-cycle end-of-frame pulse
//   curr_x, curr_y                : coordinate of the pixel in flight
//   march_start_out               : one-cycle raymarcher launch
//   pixel_done_in, red/green/blue_in : raymarcher result
//   fb_addr_out/fb_data_out/fb_we_out : frame-buffer write port
//   timeout_count_out             : timed-out pixels this frame (saturating)
module pixel_scheduler
  import pixel_scheduler_pkg::*;
#(
  parameter int WIDTH          = 300,
  parameter int HEIGHT         = 300,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                               clk_pixel_in,
  input  logic                               rst_in,
  input  logic                               start_in,
  output logic                               busy_out,
  output logic                               frame_done_out,
  output logic [32:0]                        curr_x,
  output logic [32:0]                        curr_y,
  output logic                               march_start_out,
  input  logic                               pixel_done_in,
  input  logic [7:0]                         red_in,
  input  logic [7:0]                         green_in,
  input  logic [7:0]                         blue_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]    fb_addr_out,
  output logic [11:0]                        fb_data_out,
  output logic                               fb_we_out,
  output logic [15:0]                        timeout_count_out
);

  localparam int AW   = $clog2(WIDTH * HEIGHT);
  localparam int CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [32:0]     XLast    = 33'(WIDTH - 1);
  localparam logic [32:0]     YLast    = 33'(HEIGHT - 1);

  state_e            state_q, state_d;
  logic [32:0]       x_q, x_d, y_q, y_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [15:0]       to_cnt_q, to_cnt_d;
  logic              done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      wait_q   <= '0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
      to_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      wait_q   <= wait_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
      to_cnt_q <= to_cnt_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    wait_d   = wait_q;
    red_d    = red_q;
    green_d  = green_q;
    blue_d   = blue_q;
    to_cnt_d = to_cnt_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_in) begin
          state_d  = StIssue;
          x_d      = '0;
          y_d      = '0;
          addr_d   = '0;
          to_cnt_d = '0;
        end
      end
      StIssue: begin
        state_d = StWait;
        wait_d  = '0;
      end
      StWait: begin
        // Completion wins over timeout on the same cycle.
        if (pixel_done_in) begin
          red_d   = red_in;
          green_d = green_in;
          blue_d  = blue_in;
          state_d = StWrite;
        end else if (wait_q == WaitLast) begin
          red_d   = '0;
          green_d = '0;
          blue_d  = '0;
          if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
          state_d = StWrite;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StWrite: begin
        if (x_q == XLast) begin
          if (y_q == YLast) begin
            // Last pixel: coordinates stay parked on it.
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            x_d     = '0;
            y_d     = y_q + 33'd1;
            addr_d  = addr_q + 1'b1;
            state_d = StIssue;
          end
        end else begin
          x_d     = x_q + 33'd1;
          addr_d  = addr_q + 1'b1;
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy_out        = (state_q != StIdle);
    march_start_out = (state_q == StIssue);
    fb_we_out       = (state_q == StWrite);
  end

  assign frame_done_out    = done_q;
  assign curr_x            = x_q;
  assign curr_y            = y_q;
  assign fb_addr_out       = addr_q;
  assign timeout_count_out = to_cnt_q;

  pixel_pack u_pack (
    .red_i   (red_q),
    .green_i (green_q),
    .blue_i  (blue_q),
    .x0_i    (x_q[0]),
    .y0_i    (y_q[0]),
    .pixel_o (fb_data_out)
  );

endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 300, frame width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 300, frame height in pixels.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum wait for pixel_done_in per pixel.
REQ-004 SHALL have ports: clk_pixel_in  in  1  sole clock; rst_in  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: start_in  in  1  frame start pulse; busy_out  out  1  frame in progress; frame_done_out  out  1  one-cycle end-of-frame pulse.
REQ-006 SHALL have ports: curr_x  out  33  pixel x to raymarcher; curr_y  out  33  pixel y to raymarcher; march_start_out  out  1  one-cycle pixel launch pulse.
REQ-007 SHALL have ports: pixel_done_in  in  1  raymarcher completion; red_in, green_in, blue_in  in  8 each  raymarcher colour.
REQ-008 SHALL have ports: fb_addr_out  out  $clog2(WIDTH*HEIGHT)  frame buffer address; fb_data_out  out  12  packed 4:4:4 RGB; fb_we_out  out  1  write strobe.
REQ-009 SHALL have port timeout_count_out  out  16  timed-out pixels in current frame.

Function
REQ-010 SHALL implement FSM IDLE, ISSUE, WAIT, WRITE.
REQ-011 IDLE: start_in=1 -> ISSUE, x=y=0, addr=0, timeout count cleared; start_in in any other state ignored.
REQ-012 ISSUE: march_start_out=1 for exactly that cycle, curr_x/curr_y already valid; next state WAIT, wait counter cleared.
REQ-013 curr_x/curr_y SHALL stay constant from ISSUE until the following ISSUE.
REQ-014 WAIT: pixel_done_in=1 -> register red/green/blue_in that cycle, go WRITE.
REQ-015 WAIT: counter reaching TIMEOUT_CYCLES-1 without pixel_done_in -> register colour 0, increment timeout_count_out (saturating at 16'hFFFF), go WRITE.
REQ-016 pixel_done_in outside WAIT SHALL be ignored; pixel_done_in on the timeout cycle counts as done, not timeout.
REQ-017 WRITE: fb_we_out=1 for one cycle, fb_addr_out = y*WIDTH+x (maintained incrementally, no multiplier), fb_data_out = {r[7:4],g[7:4],b[7:4]}.
REQ-018 Raster order, x fastest: after WRITE, x<WIDTH-1 -> x+1; else x=0, y+1; then ISSUE.
REQ-019 WRITE of pixel (WIDTH-1,HEIGHT-1) -> frame_done_out=1 next cycle, state IDLE, x,y held.
REQ-020 busy_out=1 in every state except IDLE.
REQ-021 Pixel throughput SHALL be 3 cycles plus raymarcher latency (ISSUE, >=1 WAIT, WRITE).

Reset
REQ-022 rst_in SHALL take priority over all inputs, any state, including mid-frame.
REQ-023 Reset values: state IDLE; curr_x, curr_y, fb_addr_out, fb_data_out, timeout_count_out = 0; march_start_out, fb_we_out, busy_out, frame_done_out = 0.
REQ-024 A frame aborted by reset SHALL produce no further fb writes; next start_in restarts at (0,0).

Configuration
REQ-025 Macro PIXEL_DITHER_EN defined: before truncation add 2x2 Bayer threshold {0,8,12,4} indexed by {y[0],x[0]} to each 8-bit channel, saturating at 255; adds no cycles.
REQ-026 PIXEL_DITHER_EN undefined: plain truncation per REQ-017.

Structure
REQ-027 Shared package SHALL hold the FSM state enum, fb pixel type (12-bit), and Bayer table constant.
REQ-028 Sub-module pixel_pack (colour registers in, 12-bit word out, dither per REQ-025) SHALL be the only sub-module; combinational.

Verification
REQ-029 WIDTH=4,HEIGHT=3, model answers pixel_done 5 cycles after each march_start -> 12 writes, addresses 0..11 in order, one frame_done, timeout_count=0.
REQ-030 Colour r=8'hAB,g=8'h12,b=8'hF0 at (0,0), dither off -> fb_data_out=12'hA1F.
REQ-031 TIMEOUT_CYCLES=8, model never answers pixel 5 -> that write data 12'h000, timeout_count_out=1, frame completes.
REQ-032 rst_in asserted in WAIT of pixel 6 -> next cycle all outputs at reset values, no fb_we_out until new start_in, restart at address 0.
REQ-033 start_in pulsed while busy and stray pixel_done_in during ISSUE -> no effect on order, count, or addresses.
REQ-034 PIXEL_DITHER_EN, r=g=b=8'hFC at (1,0) -> each channel 255 -> 12'hFFF; at (0,0) -> 12'hFFF; 8'h08 at (0,1) -> 12'h111 (8+12=20).
